// File: rtl/toy_cipher_core.sv
// Iterative rotate/XOR toy cipher: one round per clock, encrypt or decrypt.
// Result is held in data_out until the next operation completes.
module toy_cipher_core #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ROUNDS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] key_in,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             done,
  output logic             ready,
  output logic [4:0]       round
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [4:0] LAST_ROUND = 5'(ROUNDS - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] key_q, key_d;
  logic             mode_q, mode_d;
  logic [4:0]       round_q, round_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;

  logic [WIDTH-1:0] kr_c;
  logic [WIDTH-1:0] enc_mix_c;
  logic [WIDTH-1:0] s_next_c;
  logic             last_c;

  // Rotate left by n mod WIDTH; the doubled word makes any amount a plain shift.
  function automatic logic [WIDTH-1:0] rotl_n(input logic [WIDTH-1:0] x,
                                               input logic [4:0]       n);
    logic [2*WIDTH-1:0] t;
    int unsigned        amt;
    amt = 32'(n) % WIDTH;
    t   = {x, x} << amt;
    return t[2*WIDTH-1:WIDTH];
  endfunction

  assign kr_c      = rotl_n(key_q, round_q);
  assign enc_mix_c = s_q ^ kr_c;
  assign s_next_c  = mode_q ? ({s_q[0], s_q[WIDTH-1:1]} ^ kr_c)
                            : {enc_mix_c[WIDTH-2:0], enc_mix_c[WIDTH-1]};
  assign last_c    = mode_q ? (round_q == 5'd0) : (round_q == LAST_ROUND);

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    key_d   = key_q;
    mode_d  = mode_q;
    round_d = round_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ready_d = ready_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          s_d     = data_in;
          key_d   = key_in;
          mode_d  = mode;
          ready_d = 1'b0;
          round_d = mode ? LAST_ROUND : 5'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        s_d = s_next_c;
        if (last_c) begin
          data_d  = s_next_c;
          done_d  = 1'b1;
          ready_d = 1'b1;
          round_d = 5'd0;
          state_d = DONE;
        end else begin
          round_d = mode_q ? (round_q - 5'd1) : (round_q + 5'd1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      key_q   <= '0;
      mode_q  <= 1'b0;
      round_q <= 5'd0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      key_q   <= key_d;
      mode_q  <= mode_d;
      round_q <= round_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign data_out = data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign ready    = ready_q;
  assign round    = round_q;

endmodule
